// File: rtl/fir4_pkg.sv
// Shared definitions for the 4-tap running-sum FIR and its inverse.
// Used by fir4_hist and fir4_inverse_u (and by the forward filter).
package fir4_pkg;

  // Sample width, tap-sum width and filter depth.
  localparam int unsigned W     = 16;
  localparam int unsigned SUM_W = W + 2;
  localparam int unsigned TAPS  = 4;

  // Width of the signed reconstruction difference s[n] - s[n-1] + x[n-4].
  localparam int unsigned D_W   = W + 3;

  typedef logic [W-1:0]            sample_t;
  typedef logic [SUM_W-1:0]        sum_t;
  typedef logic signed [D_W-1:0]   diff_t;
  typedef logic [2:0]              cnt_t;

  // Reconstruction state; FAULT is only reachable with FIR4INV_CHECK_EN.
  typedef logic [1:0] state_t;
  localparam state_t WARM  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t FAULT = 2'd2;

  // Warm-up counter saturates once every history slot holds a real sample.
  localparam cnt_t CNT_FULL = cnt_t'(TAPS);

  // True when a reconstructed value cannot come from an unsigned W-bit source.
  function automatic logic out_of_range(input diff_t d);
    return |d[D_W-1:W];
  endfunction

endpackage

// File: rtl/fir4_hist.sv
// TAPS-deep shift register of reconstructed samples; slot 0 is the newest,
// the oldest entry (x[n-4] relative to the next input) is exposed.
module fir4_hist
  import fir4_pkg::*;
#(
  parameter int unsigned Width = W,
  parameter int unsigned Depth = TAPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] oldest
);

  logic [Width-1:0] taps [Depth];

  // Shift a new sample in on enable; reset restores the all-zero history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        taps[i] <= '0;
      end
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < Depth; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign oldest = taps[Depth-1];

endmodule

// File: rtl/fir4_inverse_u.sv
// Inverse of the 4-tap unsigned running-sum FIR: rebuilds x[n] from the
// tap sums via x[n] = s[n] - s[n-1] + x[n-4], starting from zero history.
// Optional macro FIR4INV_CHECK_EN adds a sticky range check on the
// reconstructed value (err output and FAULT state).
module fir4_inverse_u
  import fir4_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sum_t    s_in,
  input  logic    s_valid,
  output logic    s_ready,
  output sample_t x_out,
  output logic    x_valid,
  input  logic    x_ready,
  output logic    err
);

  logic    accept;
  logic    consume;
  sum_t    s_prev;
  sample_t h3;
  diff_t   d;
  sample_t x_new;
  cnt_t    cnt;
  cnt_t    cnt_next;
  state_t  state;
  state_t  state_next;

  // One-deep output register: free when empty or being drained this cycle.
  assign s_ready = !x_valid || x_ready;
  assign accept  = s_valid && s_ready;
  assign consume = x_valid && x_ready;

  // Reconstruction difference in W+3 signed bits; inputs are zero-extended.
  always_comb begin
    d     = $signed({1'b0, s_in}) - $signed({1'b0, s_prev}) + $signed({3'b000, h3});
    x_new = d[W-1:0];
  end

  fir4_hist #(
    .Width (W),
    .Depth (TAPS)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .en     (accept),
    .din    (x_new),
    .oldest (h3)
  );

  // Output register and previous-sum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out   <= '0;
      x_valid <= 1'b0;
      s_prev  <= '0;
    end else if (accept) begin
      x_out   <= x_new;
      x_valid <= 1'b1;
      s_prev  <= s_in;
    end else if (consume) begin
      x_valid <= 1'b0;
    end
  end

  // Warm-up counter saturates once history is fully populated.
  always_comb begin
    cnt_next = cnt;
    if (accept && (cnt != CNT_FULL)) begin
      cnt_next = cnt + cnt_t'(1);
    end
  end

  // Warm-up count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // WARM until the TAPS-th accept; FAULT (when checked) is sticky until reset.
  always_comb begin
    state_next = state;
    if ((state == WARM) && (cnt_next == CNT_FULL)) begin
      state_next = RUN;
    end
`ifdef FIR4INV_CHECK_EN
    if ((state == FAULT) || (accept && out_of_range(d))) begin
      state_next = FAULT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WARM;
    end else begin
      state <= state_next;
    end
  end

`ifdef FIR4INV_CHECK_EN
  logic err_flag;

  // Sticky fault: set on the accepting edge of an out-of-range result.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
    end else if (accept && out_of_range(d)) begin
      err_flag <= 1'b1;
    end
  end

  assign err = err_flag;
`else
  // Upper difference bits only feed the range check.
  logic unused_d_high;
  assign unused_d_high = ^d[D_W-1:W];
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir4_inverse_u.sv
// Self-checking bench for fir4_inverse_u with directed vectors and a
// randomised loopback through a forward-filter model.
module tb_fir4_inverse_u;
  import fir4_pkg::*;

  logic    clk;
  logic    reset;
  sum_t    s_in;
  logic    s_valid;
  logic    s_ready;
  sample_t x_out;
  logic    x_valid;
  logic    x_ready;
  logic    err;

  int checks;
  int errors;

  fir4_inverse_u dut (
    .clk     (clk),
    .reset   (reset),
    .s_in    (s_in),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .x_out   (x_out),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIR4INV_CHECK_EN
  localparam logic   ExpFaultErr   = 1'b1;
  localparam state_t ExpFaultState = FAULT;
`else
  localparam logic   ExpFaultErr   = 1'b0;
  localparam state_t ExpFaultState = WARM;
`endif

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_in    = '0;
    x_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one sum for one cycle (x_ready=1), then check output and state.
  task automatic send_check(input sum_t s, input sample_t exp_x, input state_t exp_st,
                            input string name);
    @(negedge clk);
    s_valid = 1'b1;
    s_in    = s;
    x_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (x_valid !== 1'b1 || x_out !== exp_x) begin
      errors++;
      $display("FAIL %s: x_valid=%b x_out=%h, required x_valid=1 x_out=%h",
               name, x_valid, x_out, exp_x);
    end
    checks++;
    if (dut.state !== exp_st) begin
      errors++;
      $display("FAIL %s state: got %0d, required %0d", name, dut.state, exp_st);
    end
  endtask

  task automatic test_reset();
    do_reset();
    x_ready = 1'b0;
    #1;
    checks++;
    if (x_out !== 16'h0 || x_valid !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset outputs: x_out=%h x_valid=%b err=%b s_ready=%b, required 0 0 0 1",
               x_out, x_valid, err, s_ready);
    end
    checks++;
    if (dut.state !== WARM) begin
      errors++;
      $display("FAIL reset state: got %0d, required %0d", dut.state, WARM);
    end
  endtask

  task automatic test_constant();
    do_reset();
    send_check(18'd100, 16'd100, WARM, "const1");
    send_check(18'd200, 16'd100, WARM, "const2");
    send_check(18'd300, 16'd100, WARM, "const3");
    send_check(18'd400, 16'd100, RUN,  "const4");
    send_check(18'd400, 16'd100, RUN,  "const5");
    send_check(18'd400, 16'd100, RUN,  "const6");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL const err: got %b, required 0", err);
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    send_check(18'h0FFFF, 16'hFFFF, WARM, "full1");
    send_check(18'h1FFFE, 16'hFFFF, WARM, "full2");
    send_check(18'h2FFFD, 16'hFFFF, WARM, "full3");
    send_check(18'h3FFFC, 16'hFFFF, RUN,  "full4");
    send_check(18'h3FFFC, 16'hFFFF, RUN,  "full5");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL full err: got %b, required 0", err);
    end
  endtask

  task automatic test_back_to_back();
    sum_t sums [6];
    sums = '{18'd100, 18'd200, 18'd300, 18'd400, 18'd400, 18'd400};
    do_reset();
    x_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (x_valid !== 1'b1 || x_out !== 16'd100 || s_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b[%0d]: x_valid=%b x_out=%0d s_ready=%b, required 1 100 1",
                   i, x_valid, x_out, s_ready);
        end
      end
      s_valid = 1'b1;
      s_in    = sums[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (x_out !== 16'd100 || dut.state !== RUN) begin
      errors++;
      $display("FAIL b2b last: x_out=%0d state=%0d, required 100 %0d", x_out, dut.state, RUN);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    x_ready = 1'b0;
    s_valid = 1'b1;
    s_in    = 18'd100;
    @(posedge clk);
    @(negedge clk);
    s_in = 18'd200;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0 || x_valid !== 1'b1 || x_out !== 16'd100 || dut.cnt !== 3'd1) begin
        errors++;
        $display("FAIL bp hold[%0d]: s_ready=%b x_valid=%b x_out=%0d cnt=%0d, required 0 1 100 1",
                 i, s_ready, x_valid, x_out, dut.cnt);
      end
      @(negedge clk);
    end
    x_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp release s_ready: got %b, required 1", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (x_valid !== 1'b1 || x_out !== 16'd100 || dut.cnt !== 3'd2) begin
      errors++;
      $display("FAIL bp resume: x_valid=%b x_out=%0d cnt=%0d, required 1 100 2",
               x_valid, x_out, dut.cnt);
    end
    send_check(18'd300, 16'd100, WARM, "bp3");
    send_check(18'd400, 16'd100, RUN,  "bp4");
    send_check(18'd400, 16'd100, RUN,  "bp5");
  endtask

  task automatic test_inconsistent();
    do_reset();
    send_check(18'd5, 16'd5, WARM, "incons1");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL incons err before: got %b, required 0", err);
    end
    send_check(18'd0, 16'hFFFB, ExpFaultState, "incons2");
    checks++;
    if (err !== ExpFaultErr) begin
      errors++;
      $display("FAIL incons err: got %b, required %b", err, ExpFaultErr);
    end
    // Datapath keeps running; err stays sticky.
    send_check(18'd5, 16'd5, ExpFaultState, "incons3");
    checks++;
    if (err !== ExpFaultErr) begin
      errors++;
      $display("FAIL incons err sticky: got %b, required %b", err, ExpFaultErr);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    send_check(18'd7,  16'd7, WARM, "mid1");
    send_check(18'd14, 16'd7, WARM, "mid2");
    send_check(18'd21, 16'd7, WARM, "mid3");
    do_reset();
    send_check(18'd9, 16'd9, WARM, "mid_after_reset");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL mid err: got %b, required 0", err);
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 1000;
    sample_t src [N];
    sum_t    sums [N];
    int      in_idx;
    int      out_idx;
    int      cycles;
    logic    acc;
    for (int i = 0; i < N; i++) begin
      src[i] = sample_t'($urandom());
    end
    for (int i = 0; i < N; i++) begin
      sums[i] = sum_t'(src[i]);
      for (int k = 1; k < 4; k++) begin
        if (i - k >= 0) sums[i] = sums[i] + sum_t'(src[i-k]);
      end
    end
    do_reset();
    in_idx  = 0;
    out_idx = 0;
    cycles  = 0;
    while (out_idx < N && cycles < 20000) begin
      @(negedge clk);
      s_valid = (in_idx < N) && ($urandom_range(0, 3) != 0);
      s_in    = (in_idx < N) ? sums[in_idx] : '0;
      x_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = s_valid && s_ready;
      if (x_valid && x_ready) begin
        checks++;
        if (x_out !== src[out_idx]) begin
          errors++;
          $display("FAIL random[%0d]: x_out=%h, required %h", out_idx, x_out, src[out_idx]);
        end
        out_idx++;
      end
      @(posedge clk);
      if (acc) in_idx++;
      cycles++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (out_idx != N || in_idx != N) begin
      errors++;
      $display("FAIL random count: out=%0d in=%0d, required %0d", out_idx, in_idx, N);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL random err: got %b, required 0", err);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_in    = '0;
    x_ready = 1'b1;
    test_reset();
    test_constant();
    test_full_scale();
    test_back_to_back();
    test_backpressure();
    test_inconsistent();
    test_reset_midstream();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
